// File: rtl/digit_glyph_tx.sv
// Digit-to-glyph transmitter: accepts a digit, latches its 5x4 pixel glyph as a
// parallel frame and streams it out one 4-bit row at a time over valid/ready.
module digit_glyph_tx #(
    parameter int unsigned GAP_CYCLES = 2,
    parameter bit          INVERT     = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  digit,
    output logic [19:0] frame,
    output logic        bad_digit,
    output logic        row_valid,
    input  logic        row_ready,
    output logic [3:0]  row_data,
    output logic [2:0]  row_idx,
    output logic        row_last,
    output logic [7:0]  frame_count
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam int unsigned   GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [19:0]   INV_MASK = INVERT ? 20'hFFFFF : 20'h00000;

    state_t        state;
    logic [19:0]   shreg;
    logic [GW-1:0] gap_cnt;
    logic [19:0]   glyph_in;

    function automatic logic [19:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 20'hF999F;
            4'd1:    return 20'h26227;
            4'd2:    return 20'hF1F8F;
            4'd3:    return 20'hF171F;
            4'd4:    return 20'h99F11;
            4'd5:    return 20'hF8F1F;
            4'd6:    return 20'hF8F9F;
            4'd7:    return 20'hF1244;
            4'd8:    return 20'hF9F9F;
            4'd9:    return 20'hF9F1F;
            default: return 20'h00000;
        endcase
    endfunction

    always_comb begin
        glyph_in = glyph(digit) ^ INV_MASK;
    end

    // The current row is always the top nibble of the shift register.
    assign row_data = shreg[19:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            frame       <= '0;
            bad_digit   <= 1'b0;
            row_valid   <= 1'b0;
            row_idx     <= '0;
            row_last    <= 1'b0;
            frame_count <= '0;
            shreg       <= '0;
            gap_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        frame     <= glyph_in;
                        shreg     <= glyph_in;
                        bad_digit <= (digit > 4'd9);
                        row_idx   <= '0;
                        row_last  <= 1'b0;
                        row_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (row_ready) begin
                        shreg <= {shreg[15:0], 4'h0};
                        if (row_idx == 3'd4) begin
                            row_valid   <= 1'b0;
                            row_idx     <= '0;
                            row_last    <= 1'b0;
                            frame_count <= frame_count + 8'd1;
                            gap_cnt     <= '0;
                            if (GAP_CYCLES == 0) begin
                                state    <= IDLE;
                                in_ready <= 1'b1;
                            end else begin
                                state <= GAP;
                            end
                        end else begin
                            row_idx  <= row_idx + 3'd1;
                            row_last <= (row_idx == 3'd3);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_glyph_tx.sv
// Scoreboard bench for digit_glyph_tx: one instance with default parameters,
// one with INVERT=1 and GAP_CYCLES=0.
module tb_digit_glyph_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_in_valid, a_in_ready, a_bad, a_row_valid, a_row_ready, a_row_last;
    logic [3:0]  a_digit, a_row_data;
    logic [19:0] a_frame;
    logic [2:0]  a_row_idx;
    logic [7:0]  a_fc;

    logic        b_rst, b_in_valid, b_in_ready, b_bad, b_row_valid, b_row_ready, b_row_last;
    logic [3:0]  b_digit, b_row_data;
    logic [19:0] b_frame;
    logic [2:0]  b_row_idx;
    logic [7:0]  b_fc;

    digit_glyph_tx #(.GAP_CYCLES(2), .INVERT(1'b0)) dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .digit(a_digit), .frame(a_frame), .bad_digit(a_bad), .row_valid(a_row_valid),
        .row_ready(a_row_ready), .row_data(a_row_data), .row_idx(a_row_idx),
        .row_last(a_row_last), .frame_count(a_fc)
    );

    digit_glyph_tx #(.GAP_CYCLES(0), .INVERT(1'b1)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .digit(b_digit), .frame(b_frame), .bad_digit(b_bad), .row_valid(b_row_valid),
        .row_ready(b_row_ready), .row_data(b_row_data), .row_idx(b_row_idx),
        .row_last(b_row_last), .frame_count(b_fc)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [19:0] rom [0:9] = '{20'hF999F, 20'h26227, 20'hF1F8F, 20'hF171F, 20'h99F11,
                               20'hF8F1F, 20'hF8F9F, 20'hF1244, 20'hF9F9F, 20'hF9F1F};

    logic [7:0]  sb_a[$];
    logic [7:0]  sb_b[$];
    int unsigned b_acc[$];
    bit          a_stall = 0, b_stall = 0;
    logic [7:0]  a_hold, b_hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] exp_glyph(input logic [3:0] d, input bit inv);
        logic [19:0] g;
        g = (d < 4'd10) ? rom[d] : 20'h00000;
        return inv ? ~g : g;
    endfunction

    function automatic logic [7:0] exp_row(input logic [19:0] g, input int r);
        logic [19:0] s;
        s = g >> (16 - 4 * r);
        return {(r == 4), 3'(r), s[3:0]};
    endfunction

    // Monitors sample mid-cycle; a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (a_rst) begin
            sb_a.delete();
            a_stall = 0;
        end else begin
            if (a_in_valid && a_in_ready)
                for (int r = 0; r < 5; r++) sb_a.push_back(exp_row(exp_glyph(a_digit, 1'b0), r));
            if (a_row_valid) begin
                if (a_stall) check("a_hold", {a_row_last, a_row_idx, a_row_data}, a_hold);
                if (a_row_ready) begin
                    a_stall = 0;
                    if (sb_a.size() == 0) check("a_extra_row", 1, 0);
                    else check("a_row", {a_row_last, a_row_idx, a_row_data}, sb_a.pop_front());
                end else begin
                    a_stall = 1;
                    a_hold  = {a_row_last, a_row_idx, a_row_data};
                end
            end else a_stall = 0;
        end
    end

    always @(negedge clk) begin
        if (b_rst) begin
            sb_b.delete();
            b_stall = 0;
        end else begin
            if (b_in_valid && b_in_ready) begin
                b_acc.push_back(cyc);
                for (int r = 0; r < 5; r++) sb_b.push_back(exp_row(exp_glyph(b_digit, 1'b1), r));
            end
            if (b_row_valid) begin
                if (b_stall) check("b_hold", {b_row_last, b_row_idx, b_row_data}, b_hold);
                if (b_row_ready) begin
                    b_stall = 0;
                    if (sb_b.size() == 0) check("b_extra_row", 1, 0);
                    else check("b_row", {b_row_last, b_row_idx, b_row_data}, sb_b.pop_front());
                end else begin
                    b_stall = 1;
                    b_hold  = {b_row_last, b_row_idx, b_row_data};
                end
            end else b_stall = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready_a();
        int unsigned i;
        i = 0;
        while (!a_in_ready && i < 50) begin tick(); i++; end
        check("a_ready_wait", a_in_ready, 1);
    endtask

    task automatic send_a(input logic [3:0] d, input logic [3:0] pat);
        int unsigned i;
        wait_ready_a();
        a_digit = d;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        check("a_frame", a_frame, exp_glyph(d, 1'b0));
        check("a_bad", a_bad, d > 4'd9);
        check("a_busy", a_in_ready, 0);
        i = 0;
        while (a_row_valid && i < 60) begin
            a_row_ready = pat[i % 4];
            tick();
            i++;
        end
        check("a_rv_done", a_row_valid, 0);
        check("a_sb_empty", sb_a.size(), 0);
        a_row_ready = 1'b1;
    endtask

    initial begin
        int unsigned i;
        a_rst = 1; a_in_valid = 0; a_digit = 0; a_row_ready = 0;
        b_rst = 1; b_in_valid = 0; b_digit = 0; b_row_ready = 0;
        repeat (2) tick();
        a_rst = 0; b_rst = 0;

        check("rst_in_ready", a_in_ready, 1);
        check("rst_frame", a_frame, 0);
        check("rst_fc", a_fc, 0);
        check("rst_row_valid", a_row_valid, 0);
        check("rst_bad", a_bad, 0);
        check("rst_row_idx", a_row_idx, 0);
        check("rst_b_in_ready", b_in_ready, 1);

        // digit 0, row_ready held high, exact turnaround
        a_row_ready = 1; a_digit = 0; a_in_valid = 1;
        tick();
        a_in_valid = 0;
        check("t1_frame", a_frame, 20'hF999F);
        check("t1_row_valid", a_row_valid, 1);
        repeat (5) tick();
        check("t1_done_rv", a_row_valid, 0);
        check("t1_fc", a_fc, 1);
        check("t1_ready_gap0", a_in_ready, 0);
        tick();
        check("t1_ready_gap1", a_in_ready, 0);
        tick();
        check("t1_ready_gap2", a_in_ready, 1);
        check("t1_sb_empty", sb_a.size(), 0);

        send_a(4'd7, 4'b1001);
        check("t2_fc", a_fc, 2);
        send_a(4'd12, 4'b1111);
        check("t3_bad_hold", a_bad, 1);
        send_a(4'd3, 4'b0110);
        check("t3_fc", a_fc, 4);

        // reset in the middle of row 2
        wait_ready_a();
        a_digit = 8; a_in_valid = 1;
        tick();
        a_in_valid = 0;
        repeat (2) tick();
        check("t5_row_idx", a_row_idx, 2);
        a_rst = 1;
        tick();
        a_rst = 0;
        check("t5_rv", a_row_valid, 0);
        check("t5_frame", a_frame, 0);
        check("t5_fc", a_fc, 0);
        check("t5_ready", a_in_ready, 1);
        check("t5_idx", a_row_idx, 0);
        send_a(4'd8, 4'b1111);
        check("t5_fc_after", a_fc, 1);

        // counter wrap, cycling through every valid digit
        for (int k = 1; k < 255; k++) send_a(4'(k % 10), 4'b1111);
        check("t6_fc_255", a_fc, 255);
        send_a(4'd5, 4'b1011);
        check("t6_fc_wrap", a_fc, 0);

        // inverted glyphs, no gap
        b_row_ready = 1; b_digit = 1; b_in_valid = 1;
        tick();
        b_in_valid = 0;
        check("t4_frame", b_frame, 20'hD9DD8);
        check("t4_busy", b_in_ready, 0);
        repeat (5) tick();
        check("t4_ready_now", b_in_ready, 1);
        check("t4_rv", b_row_valid, 0);
        b_acc.delete();
        b_in_valid = 1;
        repeat (18) tick();
        b_in_valid = 0;
        i = 0;
        while (b_row_valid && i < 20) begin tick(); i++; end
        check("t4_accepts", b_acc.size(), 3);
        if (b_acc.size() == 3) begin
            check("t4_period1", b_acc[1] - b_acc[0], 6);
            check("t4_period2", b_acc[2] - b_acc[1], 6);
        end
        check("t4_fc", b_fc, 4);
        b_digit = 12; b_in_valid = 1;
        tick();
        b_in_valid = 0;
        check("t4_bad_frame", b_frame, 20'hFFFFF);
        check("t4_bad", b_bad, 1);
        repeat (6) tick();
        check("t4_sb_empty", sb_b.size(), 0);
        check("t4_fc_end", b_fc, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
